// File: rtl/bsg_fsb_node_iso_pkg.sv
// Shared state encoding, timeout constant and sizing helper for the FSB node
// isolation controller.
package bsg_fsb_node_iso_pkg;

  typedef enum logic [2:0] {
    ISO_OFF      = 3'd0,
    ISO_PWR_WAIT = 3'd1,
    ISO_SETTLE   = 3'd2,
    ISO_NODE_RST = 3'd3,
    ISO_ACTIVE   = 3'd4,
    ISO_DRAIN    = 3'd5,
    ISO_ISOLATE  = 3'd6
  } bsg_fsb_node_iso_state_e;

  localparam int bsg_fsb_node_iso_timeout_gp = 1024;

  // Ceiling log2 that never returns 0, so a width derived from it is legal.
  function automatic int bsg_fsb_node_iso_safe_clog2(input int x);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < x) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bsg_fsb_node_isolation_ctrl_if.sv
// Handshake and data bundle between the FSB ring port, the isolation
// controller (master) and the node-side level-shift wrapper / FSB (slave).
interface bsg_fsb_node_isolation_ctrl_if #(parameter int ring_width_p = 16);

  logic                    fsb_v_i;
  logic [ring_width_p-1:0] fsb_data_i;
  logic                    fsb_yumi_o;
  logic                    ls_v_o;
  logic [ring_width_p-1:0] ls_data_o;
  logic                    ls_yumi_i;
  logic                    ls_v_i;
  logic [ring_width_p-1:0] ls_data_i;
  logic                    ls_ready_o;
  logic                    fsb_v_o;
  logic [ring_width_p-1:0] fsb_data_o;
  logic                    fsb_ready_i;

  modport master (
    input  fsb_v_i, fsb_data_i, ls_yumi_i, ls_v_i, ls_data_i, fsb_ready_i,
    output fsb_yumi_o, ls_v_o, ls_data_o, ls_ready_o, fsb_v_o, fsb_data_o
  );

  modport slave (
    output fsb_v_i, fsb_data_i, ls_yumi_i, ls_v_i, ls_data_i, fsb_ready_i,
    input  fsb_yumi_o, ls_v_o, ls_data_o, ls_ready_o, fsb_v_o, fsb_data_o
  );

endinterface

// File: rtl/bsg_fsb_node_iso_gate.sv
// Combinational handshake gating between the FSB and the level-shift wrapper.
// Data always flows; only the valid/ready/yumi qualifiers are gated.
module bsg_fsb_node_iso_gate #(
  parameter int ring_width_p = 16
) (
  input  logic                    pass_f2n,
  input  logic                    pass_n2f,
  input  logic                    fsb_v,
  input  logic [ring_width_p-1:0] fsb_data,
  input  logic                    ls_yumi,
  input  logic                    ls_v,
  input  logic [ring_width_p-1:0] ls_data,
  input  logic                    fsb_ready,
  output logic                    ls_v_gated,
  output logic [ring_width_p-1:0] ls_data_out,
  output logic                    fsb_yumi_gated,
  output logic                    fsb_v_gated,
  output logic [ring_width_p-1:0] fsb_data_out,
  output logic                    ls_ready_gated
);

  assign ls_v_gated     = pass_f2n & fsb_v;
  assign fsb_yumi_gated = pass_f2n & ls_yumi;
  assign fsb_v_gated    = pass_n2f & ls_v;
  assign ls_ready_gated = pass_n2f & fsb_ready;
  assign ls_data_out    = fsb_data;
  assign fsb_data_out   = ls_data;

endmodule

// File: rtl/bsg_fsb_node_isolation_ctrl.sv
// Power-up / drain / isolate sequencer for a separately powered FSB node.
// Optional BSG_FSB_NODE_ISO_DRAIN_TIMEOUT_EN adds a forced-isolate drain timeout.
//
// state    | meaning
// OFF      | supply off, shifter off, node held in reset
// PWR_WAIT | supply enabled, waiting for power-good
// SETTLE   | supply good, letting node rails settle
// NODE_RST | shifter on, node reset still asserted
// ACTIVE   | traffic flows both ways
// DRAIN    | inbound blocked, outbound drains until idle
// ISOLATE  | shifter off for one cycle before supply removal
module bsg_fsb_node_isolation_ctrl
  import bsg_fsb_node_iso_pkg::*;
#(
  parameter int ring_width_p    = 16,
  parameter int settle_cycles_p = 16,
  parameter int reset_cycles_p  = 8,
  parameter int drain_cycles_p  = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic power_req_i,
  input  logic pwr_good_i,
  output logic pwr_en_o,
  output logic en_ls_o,
  output logic node_reset_o,
  output logic active_o,
`ifdef BSG_FSB_NODE_ISO_DRAIN_TIMEOUT_EN
  output logic drain_timeout_o,
`endif
  bsg_fsb_node_isolation_ctrl_if.master io
);

  localparam logic [2:0] s_off      = ISO_OFF;
  localparam logic [2:0] s_pwr_wait = ISO_PWR_WAIT;
  localparam logic [2:0] s_settle   = ISO_SETTLE;
  localparam logic [2:0] s_node_rst = ISO_NODE_RST;
  localparam logic [2:0] s_active   = ISO_ACTIVE;
  localparam logic [2:0] s_drain    = ISO_DRAIN;
  localparam logic [2:0] s_isolate  = ISO_ISOLATE;

  localparam int max_sr_lp = (settle_cycles_p > reset_cycles_p) ? settle_cycles_p : reset_cycles_p;
  localparam int max_lp    = (max_sr_lp > drain_cycles_p) ? max_sr_lp : drain_cycles_p;
  localparam int cnt_w_lp  = bsg_fsb_node_iso_safe_clog2(max_lp) + 1;

  localparam logic [cnt_w_lp-1:0] settle_last_lp = cnt_w_lp'(settle_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] reset_last_lp  = cnt_w_lp'(reset_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] drain_done_lp  = cnt_w_lp'(drain_cycles_p);

  logic [2:0]          state_r, state_n;
  logic [cnt_w_lp-1:0] cnt_r, cnt_n, cnt_inc;
  logic                to_expire;

  assign cnt_inc = (cnt_r == '1) ? cnt_r : cnt_r + cnt_w_lp'(1);

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      s_off: if (power_req_i) state_n = s_pwr_wait;
      s_pwr_wait: begin
        if (!power_req_i) state_n = s_off;
        else if (pwr_good_i) begin
          state_n = s_settle;
          cnt_n   = '0;
        end
      end
      s_settle: begin
        if (!power_req_i || !pwr_good_i) state_n = s_isolate;
        else if (cnt_r == settle_last_lp) begin
          state_n = s_node_rst;
          cnt_n   = '0;
        end else cnt_n = cnt_inc;
      end
      s_node_rst: begin
        if (!power_req_i || !pwr_good_i) state_n = s_isolate;
        else if (cnt_r == reset_last_lp) begin
          state_n = s_active;
          cnt_n   = '0;
        end else cnt_n = cnt_inc;
      end
      s_active: begin
        if (!pwr_good_i) state_n = s_isolate;
        else if (!power_req_i) begin
          state_n = s_drain;
          cnt_n   = '0;
        end
      end
      s_drain: begin
        // cnt_n is the idle run length including this cycle
        cnt_n = io.ls_v_i ? '0 : cnt_inc;
        if (!pwr_good_i) state_n = s_isolate;
        else if (power_req_i) state_n = s_active;
        else if (cnt_n == drain_done_lp || to_expire) state_n = s_isolate;
      end
      s_isolate: state_n = s_off;
      default:   state_n = s_off;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= s_off;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

`ifdef BSG_FSB_NODE_ISO_DRAIN_TIMEOUT_EN
  logic [9:0] to_cnt_r;
  logic       timeout_r;

  assign to_expire = (state_r == s_drain) && (to_cnt_r == 10'(bsg_fsb_node_iso_timeout_gp - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      to_cnt_r  <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (state_r != s_drain) to_cnt_r <= '0;
      else if (!to_expire)    to_cnt_r <= to_cnt_r + 10'd1;
      if (state_n == s_pwr_wait && state_r != s_pwr_wait) timeout_r <= 1'b0;
      else if (to_expire && state_n == s_isolate)        timeout_r <= 1'b1;
    end
  end

  assign drain_timeout_o = timeout_r;
`else
  assign to_expire = 1'b0;
`endif

  // Shifter is only enabled in states where the supply is already on.
  assign pwr_en_o     = (state_r != s_off);
  assign en_ls_o      = (state_r == s_node_rst) || (state_r == s_active) || (state_r == s_drain);
  assign node_reset_o = !((state_r == s_active) || (state_r == s_drain));
  assign active_o     = (state_r == s_active);

  logic pass_f2n, pass_n2f;
  assign pass_f2n = (state_r == s_active);
  assign pass_n2f = (state_r == s_active) || (state_r == s_drain);

  logic                    ls_v_w, fsb_yumi_w, fsb_v_w, ls_ready_w;
  logic [ring_width_p-1:0] ls_data_w, fsb_data_w;

  bsg_fsb_node_iso_gate #(.ring_width_p(ring_width_p)) gate (
    .pass_f2n       (pass_f2n),
    .pass_n2f       (pass_n2f),
    .fsb_v          (io.fsb_v_i),
    .fsb_data       (io.fsb_data_i),
    .ls_yumi        (io.ls_yumi_i),
    .ls_v           (io.ls_v_i),
    .ls_data        (io.ls_data_i),
    .fsb_ready      (io.fsb_ready_i),
    .ls_v_gated     (ls_v_w),
    .ls_data_out    (ls_data_w),
    .fsb_yumi_gated (fsb_yumi_w),
    .fsb_v_gated    (fsb_v_w),
    .fsb_data_out   (fsb_data_w),
    .ls_ready_gated (ls_ready_w)
  );

  assign io.ls_v_o     = ls_v_w;
  assign io.ls_data_o  = ls_data_w;
  assign io.fsb_yumi_o = fsb_yumi_w;
  assign io.fsb_v_o    = fsb_v_w;
  assign io.fsb_data_o = fsb_data_w;
  assign io.ls_ready_o = ls_ready_w;

endmodule

// File: doc/bsg_fsb_node_isolation_ctrl.md
Name: bsg_fsb_node_isolation_ctrl

Overview:
- FSB-domain sequencer that brings a separately powered FSB node up and down safely.
- It drives the node power enable, the level-shifter enable (en_ls) and the node reset.
- It gates the valid/ready/yumi handshake between the FSB and the node-domain level-shift wrapper, so no traffic crosses while the node is unpowered, settling or draining.
- It sits between the FSB ring port and the level-shift wrapper.

Parameters:
- ring_width_p, "inv", FSB packet width.
- settle_cycles_p, 16, cycles from power-good until en_ls_o is asserted.
- reset_cycles_p, 8, cycles node_reset_o stays high after en_ls_o rises.
- drain_cycles_p, 4, consecutive idle node->FSB cycles required before isolation.

Ports:
- clk_i  in  1  FSB clock.
- reset_i  in  1  synchronous, active-high reset.
- power_req_i  in  1  level request: 1 = node on, 0 = node off.
- pwr_good_i  in  1  node supply is stable.
- pwr_en_o  out  1  node supply switch enable.
- en_ls_o  out  1  level-shifter enable.
- node_reset_o  out  1  node reset, passed through the shifter.
- active_o  out  1  traffic permitted.
- fsb_v_i  in  1  FSB->node valid.
- fsb_data_i  in  ring_width_p  FSB->node data.
- fsb_yumi_o  out  1  FSB->node consume.
- ls_v_o  out  1  valid toward the shifter.
- ls_data_o  out  ring_width_p  data toward the shifter.
- ls_yumi_i  in  1  consume from the shifter.
- ls_v_i  in  1  node->FSB valid from the shifter.
- ls_data_i  in  ring_width_p  node->FSB data.
- ls_ready_o  out  1  ready toward the shifter.
- fsb_v_o  out  1  node->FSB valid to the FSB.
- fsb_data_o  out  ring_width_p  node->FSB data to the FSB.
- fsb_ready_i  in  1  FSB ready.

Behaviour:
- Single clock domain: clk_i. Reset is synchronous and active-high on reset_i.
- State machine states: OFF, PWR_WAIT, SETTLE, NODE_RST, ACTIVE, DRAIN, ISOLATE.
- Reset, or any cycle with reset_i high, including mid-operation:
  - state goes to OFF; counter cleared.
  - pwr_en_o=0, en_ls_o=0, node_reset_o=1, active_o=0.
  - ls_v_o=fsb_yumi_o=fsb_v_o=ls_ready_o=0.
- All control outputs are registered or decoded from state only. They never depend combinationally on power_req_i.
- OFF: power_req_i=1 -> PWR_WAIT.
- PWR_WAIT:
  - pwr_en_o=1.
  - pwr_good_i=1 -> SETTLE, counter cleared.
  - power_req_i=0 -> OFF. Power-request loss has priority.
- SETTLE:
  - pwr_en_o=1.
  - Counter increments each cycle; at settle_cycles_p-1 -> NODE_RST.
  - power_req_i=0 or pwr_good_i=0 -> ISOLATE.
- NODE_RST:
  - en_ls_o=1, node_reset_o=1, for reset_cycles_p cycles, then -> ACTIVE.
  - power_req_i=0 or pwr_good_i=0 -> ISOLATE.
- ACTIVE:
  - en_ls_o=1, node_reset_o=0, active_o=1.
  - Handshakes pass through: ls_v_o=fsb_v_i, fsb_yumi_o=ls_yumi_i, fsb_v_o=ls_v_i, ls_ready_o=fsb_ready_i. Data always passes unconditionally.
  - power_req_i=0 -> DRAIN, counter cleared.
  - pwr_good_i=0 -> ISOLATE immediately; traffic is lost.
- DRAIN:
  - ls_v_o=0 and fsb_yumi_o=0: no new FSB->node traffic.
  - Node->FSB path stays passed through; active_o=0.
  - Counter increments on cycles with ls_v_i=0. Any cycle with ls_v_i=1 clears it.
  - Counter reaching drain_cycles_p -> ISOLATE.
  - power_req_i=1 -> ACTIVE (re-request has priority over the drain-done condition in the same cycle).
  - pwr_good_i=0 -> ISOLATE.
- ISOLATE:
  - Lasts 1 cycle: en_ls_o=0, node_reset_o=1, pwr_en_o=1, all handshakes gated to 0.
  - Then -> OFF, where pwr_en_o=0.
  - Isolation always precedes supply removal.
- Counter width is BSG_SAFE_CLOG2 of the largest parameter plus 1. Counter saturates; it never wraps.
- Invariant: en_ls_o=1 implies pwr_en_o=1.

Optional Feature:
- Macro: BSG_FSB_NODE_ISO_DRAIN_TIMEOUT_EN.
- With the macro defined:
  - Adds output drain_timeout_o (1 bit) and a 10-bit drain-timeout counter.
  - A DRAIN lasting 1024 cycles without completing forces ISOLATE.
  - drain_timeout_o is a sticky 1 until reset_i or the next entry to PWR_WAIT.
- Without the macro: DRAIN may last indefinitely, and the port and counter are absent.

Decomposition:
- Shared package bsg_fsb_node_iso_pkg holds:
  - the state enum, bsg_fsb_node_iso_state_e (7 states, 3 bits);
  - the timeout constant bsg_fsb_node_iso_timeout_gp = 1024.
- Sub-module bsg_fsb_node_iso_gate: the combinational handshake gating, driven by pass_f2n/pass_n2f enables decoded from state.
- The FSM and counters live in the top module.

Test Plan:
- Power-up (settle_cycles_p=4, reset_cycles_p=8): power_req_i=1, pwr_good_i rises at cycle 5.
  - Required: en_ls_o rises 4 cycles after SETTLE entry.
  - Required: node_reset_o falls and active_o rises 8 cycles after that.
  - Required: pwr_en_o=1 throughout.
- ACTIVE traffic: fsb_v_i=1, data=0xA5, ls_yumi_i=1.
  - Required: ls_v_o=1, ls_data_o=0xA5, fsb_yumi_o=1 in the same cycle.
  - Required: ls_v_i=1 with fsb_ready_i=1 gives fsb_v_o=1.
- Drain (drain_cycles_p=3): drop power_req_i while ls_v_i pulses at drain cycles 1 and 3.
  - Required: ls_v_o=0 immediately.
  - Required: ISOLATE only after 3 consecutive idle cycles.
  - Required: en_ls_o falls one cycle before pwr_en_o.
- Re-request: power_req_i returns to 1 in the same cycle the drain count reaches 3.
  - Required: state returns to ACTIVE; en_ls_o never drops.
- Fault: pwr_good_i=0 during ACTIVE.
  - Required: next cycle en_ls_o=0, node_reset_o=1, all valids 0.
  - Required: the cycle after, pwr_en_o=0.
- Reset mid-NODE_RST: reset_i=1 for 1 cycle.
  - Required: next cycle all outputs at reset values and state OFF.
  - Required: with power_req_i still 1, PWR_WAIT on the following cycle.
